// File: rtl/uart_defs_pkg.sv
// Frame constants and FSM state encodings shared by the UART transmitter and receiver.
package uart_defs;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_DATA    = 3'd2,
      ST_STOP    = 3'd3,
      ST_CLEANUP = 3'd4
   } uart_state_t;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with valid-gated push/pop; DEPTH must be a power of 2 so pointers wrap naturally.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     i_Clock,
   input  logic                     i_Reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge i_Clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; line, active and done are registered,
// so they trail the FSM state by one cycle.
//
// state   | meaning
// IDLE    | line high; pop next byte when the FIFO is non-empty
// START   | start bit (low) for CLKS_PER_BIT cycles
// DATA    | data bits LSB first, CLKS_PER_BIT cycles each
// STOP    | stop bit (high) for CLKS_PER_BIT cycles
// CLEANUP | one cycle; raises the done pulse, then back to IDLE
module uart_tx
   import uart_defs::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                           i_Clock,
   input  logic                           i_Reset,
   input  logic                           i_Tx_DV,
   input  logic [7:0]                     i_Tx_Byte,
   output logic                           o_Tx_Ready,
   output logic                           o_Tx_Serial,
   output logic                           o_Tx_Active,
   output logic                           o_Tx_Done,
   output logic [$clog2(FIFO_DEPTH):0]    o_Fifo_Count
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   uart_state_t          state_q, state_d;
   logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
   logic [BW-1:0]        bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 serial_d, active_d, done_d;
   logic                 rdy_q;
   logic                 fifo_pop, fifo_full, fifo_empty;
   logic [7:0]           fifo_data;
   logic                 bit_end;

   // rdy_q only masks the ready flag during and immediately after reset.
   assign o_Tx_Ready = rdy_q && !fifo_full;
   assign bit_end    = (clk_cnt_q == CNT_LAST);

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .i_Clock   (i_Clock),
      .i_Reset   (i_Reset),
      .push      (i_Tx_DV && o_Tx_Ready),
      .push_data (i_Tx_Byte),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (o_Fifo_Count)
   );

   always_ff @(posedge i_Clock) begin
      if (i_Reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      fifo_pop  = 1'b0;
      serial_d  = 1'b1;
      active_d  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_data;
               bit_idx_d = '0;
               clk_cnt_d = '0;
               state_d   = ST_START;
            end
         end
         ST_START: begin
            serial_d = 1'b0;
            active_d = 1'b1;
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = ST_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            serial_d = shift_q[bit_idx_q];
            active_d = 1'b1;
            if (bit_end) begin
               clk_cnt_d = '0;
               if (bit_idx_q == BIT_LAST) state_d = ST_STOP;
               else                       bit_idx_d = bit_idx_q + 1'b1;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            active_d = 1'b1;
            if (bit_end) begin
               clk_cnt_d = '0;
               state_d   = ST_CLEANUP;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         ST_CLEANUP: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         o_Tx_Serial <= serial_d;
         o_Tx_Active <= active_d;
         o_Tx_Done   <= done_d;
         rdy_q       <= 1'b1;
      end
   end

endmodule
